neuron_bank_sequencer: RTL and testbench

- Bus initiator that drives the neuron bank's memory-mapped CPU interface so one simulation timestep runs without CPU involvement.
- Per step it writes each neuron's input current, pulses that neuron's update bit, then polls each neuron's status until it is not busy. It collects the spike bits into a vector and signals step completion.
- It sits between a timestep scheduler (or NoC input stage) and one neuron bank inside a mesh node.

---
 rtl/neuron_bank_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_neuron_bank_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_bank_sequencer.sv
// neuron_bank_sequencer
//   Bus initiator that runs one simulation timestep on an attached neuron bank
//   without CPU help. For each neuron it writes the input current (offset 0x14)
//   and then pulses the update bit in the control register (offset 0x18). After a
//   short settle gap it polls each status register (offset 0x1C) until the busy
//   bit clears, gathers the spike bits and reports completion.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cur_wr_en/idx/data host write port into the per-neuron current buffer
//   mode_cfg          per-neuron mode bit, placed in control bit 2
//   step_start        start one timestep (accepted only when idle)
//   step_busy         high from acceptance through the step_done cycle
//   step_done         one-cycle completion pulse
//   spike_vec         spike bits of the last completed step
//   timeout_err       sticky poll-timeout flag, cleared by an accepted start
//   bus_*             single-initiator memory bus (responder stalls with busywait)

module neuron_bank_sequencer #(
    parameter int NUM_NEURONS   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_POLL      = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cur_wr_en,
    input  logic [1:0]             cur_wr_idx,
    input  logic [31:0]            cur_wr_data,
    input  logic [NUM_NEURONS-1:0] mode_cfg,
    input  logic                   step_start,
    output logic                   step_busy,
    output logic                   step_done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   timeout_err,
    output logic [31:0]            bus_addr,
    output logic                   bus_write_en,
    output logic [31:0]            bus_write_data,
    output logic                   bus_read_en,
    input  logic [31:0]            bus_read_data,
    input  logic                   bus_busywait
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int PC_W  = $clog2(MAX_POLL + 1);
    localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_NEURONS - 1);
    localparam logic [PC_W-1:0]  POLL_LAST   = PC_W'(MAX_POLL - 1);
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

    localparam logic [31:0] OFF_CUR  = 32'h0000_0014;
    localparam logic [31:0] OFF_CTL  = 32'h0000_0018;
    localparam logic [31:0] OFF_STAT = 32'h0000_001C;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_CUR = 3'd1,
        WR_CTL = 3'd2,
        SETTLE = 3'd3,
        POLL   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       n_r;
    logic [PC_W-1:0]        poll_cnt_r;
    logic [SC_W-1:0]        settle_cnt_r;
    logic [31:0]            cur_buf_r    [NUM_NEURONS];
    logic [31:0]            shadow_cur_r [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] shadow_mode_r;
    logic [NUM_NEURONS-1:0] spike_next_r;

    logic                   wr_done_s;
    logic                   rd_done_s;
    logic                   poll_advance_s;
    logic [IDX_W-1:0]       n_next_s;
    logic                   unused_rd_s;

    // Neuron n occupies a 64-byte window starting at n*64.
    function automatic logic [31:0] nrn_addr(input logic [IDX_W-1:0] idx,
                                             input logic [31:0]      off);
        return (32'(idx) << 6) + off;
    endfunction

    // Control word: update bit 0 set, bit 1 clear, mode in bit 2.
    function automatic logic [31:0] ctl_word(input logic mode);
        return {29'd0, mode, 1'b0, 1'b1};
    endfunction

    assign wr_done_s   = bus_write_en & ~bus_busywait;
    assign rd_done_s   = bus_read_en & ~bus_busywait;
    assign n_next_s    = n_r + IDX_W'(1);
    assign unused_rd_s = ^bus_read_data[31:2];
    // Leave the current neuron on a not-busy answer or on its final allowed read.
    assign poll_advance_s = rd_done_s & (~bus_read_data[1] | (poll_cnt_r == POLL_LAST));

    // Host-side current buffer, writable at any time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cur_buf_r[i] <= 32'd0;
            end
        end else if (cur_wr_en && (32'(cur_wr_idx) < NUM_NEURONS)) begin
            cur_buf_r[cur_wr_idx] <= cur_wr_data;
        end
    end

    // Step sequencer: bus outputs are registered and advance only on completion,
    // which keeps them stable for the whole of a responder stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            n_r            <= '0;
            poll_cnt_r     <= '0;
            settle_cnt_r   <= '0;
            shadow_mode_r  <= '0;
            spike_next_r   <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                shadow_cur_r[i] <= 32'd0;
            end
            step_busy      <= 1'b0;
            step_done      <= 1'b0;
            spike_vec      <= '0;
            timeout_err    <= 1'b0;
            bus_addr       <= 32'd0;
            bus_write_en   <= 1'b0;
            bus_write_data <= 32'd0;
            bus_read_en    <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (step_start) begin
                        // Snapshot buffer and modes; a same-cycle host write lands
                        // in cur_buf_r only, so this step sees the old value.
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            shadow_cur_r[i] <= cur_buf_r[i];
                        end
                        shadow_mode_r  <= mode_cfg;
                        spike_next_r   <= '0;
                        n_r            <= '0;
                        timeout_err    <= 1'b0;
                        step_busy      <= 1'b1;
                        bus_addr       <= nrn_addr('0, OFF_CUR);
                        bus_write_data <= cur_buf_r[0];
                        bus_write_en   <= 1'b1;
                        state_r        <= WR_CUR;
                    end else begin
                        step_busy <= 1'b0;
                    end
                end
                WR_CUR: begin
                    if (wr_done_s) begin
                        bus_addr       <= nrn_addr(n_r, OFF_CTL);
                        bus_write_data <= ctl_word(shadow_mode_r[n_r]);
                        state_r        <= WR_CTL;
                    end
                end
                WR_CTL: begin
                    if (wr_done_s) begin
                        if (n_r == LAST_IDX) begin
                            n_r            <= '0;
                            settle_cnt_r   <= '0;
                            bus_addr       <= 32'd0;
                            bus_write_data <= 32'd0;
                            bus_write_en   <= 1'b0;
                            state_r        <= SETTLE;
                        end else begin
                            n_r            <= n_next_s;
                            bus_addr       <= nrn_addr(n_next_s, OFF_CUR);
                            bus_write_data <= shadow_cur_r[n_next_s];
                            state_r        <= WR_CUR;
                        end
                    end
                end
                SETTLE: begin
                    // Quiet gap so the cores' busy flags reflect the new triggers.
                    if (settle_cnt_r == SETTLE_LAST) begin
                        poll_cnt_r  <= '0;
                        bus_addr    <= nrn_addr(n_r, OFF_STAT);
                        bus_read_en <= 1'b1;
                        state_r     <= POLL;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SC_W'(1);
                    end
                end
                POLL: begin
                    if (poll_advance_s) begin
                        if (bus_read_data[1]) begin
                            timeout_err      <= 1'b1;
                            spike_next_r[n_r] <= 1'b0;
                        end else begin
                            spike_next_r[n_r] <= bus_read_data[0];
                        end
                        poll_cnt_r <= '0;
                        if (n_r == LAST_IDX) begin
                            bus_addr    <= 32'd0;
                            bus_read_en <= 1'b0;
                            state_r     <= DONE;
                        end else begin
                            n_r      <= n_next_s;
                            bus_addr <= nrn_addr(n_next_s, OFF_STAT);
                        end
                    end else if (rd_done_s) begin
                        poll_cnt_r <= poll_cnt_r + PC_W'(1);
                    end
                end
                DONE: begin
                    step_done <= 1'b1;
                    spike_vec <= spike_next_r;
                    state_r   <= IDLE;
                end
                default: begin
                    bus_addr       <= 32'd0;
                    bus_write_en   <= 1'b0;
                    bus_write_data <= 32'd0;
                    bus_read_en    <= 1'b0;
                    step_busy      <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_bank_sequencer.sv
// Self-checking bench for neuron_bank_sequencer: a bank stub answers status
// reads, a scoreboard queue holds the expected bus transactions of each step.
module tb_neuron_bank_sequencer;

    localparam int NN = 4;
    localparam int SC = 2;
    localparam int MP = 8;

    logic          clk;
    logic          rst;
    logic          cur_wr_en;
    logic [1:0]    cur_wr_idx;
    logic [31:0]   cur_wr_data;
    logic [NN-1:0] mode_cfg;
    logic          step_start;
    logic          step_busy;
    logic          step_done;
    logic [NN-1:0] spike_vec;
    logic          timeout_err;
    logic [31:0]   bus_addr;
    logic          bus_write_en;
    logic [31:0]   bus_write_data;
    logic          bus_read_en;
    logic [31:0]   bus_read_data;
    logic          bus_busywait;

    neuron_bank_sequencer #(
        .NUM_NEURONS(NN), .SETTLE_CYCLES(SC), .MAX_POLL(MP)
    ) dut (
        .clk(clk), .rst(rst),
        .cur_wr_en(cur_wr_en), .cur_wr_idx(cur_wr_idx), .cur_wr_data(cur_wr_data),
        .mode_cfg(mode_cfg), .step_start(step_start),
        .step_busy(step_busy), .step_done(step_done), .spike_vec(spike_vec),
        .timeout_err(timeout_err),
        .bus_addr(bus_addr), .bus_write_en(bus_write_en), .bus_write_data(bus_write_data),
        .bus_read_en(bus_read_en), .bus_read_data(bus_read_data), .bus_busywait(bus_busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t exp_q[$];

    // bench model state
    logic [31:0]   mbuf [NN];
    logic [NN-1:0] mmode;
    int            busy_reads [NN];
    logic [NN-1:0] spike_bits;
    int            exp_lat;
    logic [NN-1:0] exp_spk;
    logic          exp_to;
    int            cnt58;

    // bank stub
    int            rd_cnt [NN];
    logic          stub_clr;
    logic [1:0]    sidx;
    logic          sbusy;

    always_comb begin
        sidx          = bus_addr[7:6];
        sbusy         = rd_cnt[sidx] < busy_reads[sidx];
        bus_read_data = 32'd0;
        if (bus_addr[5:0] == 6'h1C) bus_read_data = {30'd0, sbusy, spike_bits[sidx]};
    end

    always @(posedge clk) begin
        if (stub_clr) begin
            for (int i = 0; i < NN; i++) rd_cnt[i] <= 0;
        end else if (bus_read_en && !bus_busywait) begin
            rd_cnt[bus_addr[7:6]] <= rd_cnt[bus_addr[7:6]] + 1;
        end
    end

    // bus monitor
    logic        stall_hold;
    logic [31:0] prev_addr, prev_data;
    logic        prev_we, prev_re;
    txn_t        got;

    always @(negedge clk) begin
        if (rst) begin
            stall_hold = 1'b0;
        end else begin
            if (bus_write_en && bus_addr == 32'h58) cnt58++;
            if (stall_hold) begin
                checks++;
                if (bus_addr !== prev_addr || bus_write_data !== prev_data ||
                    bus_write_en !== prev_we || bus_read_en !== prev_re) begin
                    errors++;
                    $display("FAIL stall_hold: got addr=%h data=%h we=%b re=%b, required addr=%h data=%h we=%b re=%b",
                             bus_addr, bus_write_data, bus_write_en, bus_read_en,
                             prev_addr, prev_data, prev_we, prev_re);
                end
            end
            if (bus_write_en || bus_read_en) begin
                checks++;
                if (bus_write_en && bus_read_en) begin
                    errors++;
                    $display("FAIL strobe_excl: both strobes high at addr=%h, required at most one", bus_addr);
                end
                if (!bus_busywait) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_txn: got we=%b addr=%h data=%h, required no transaction",
                                 bus_write_en, bus_addr, bus_write_data);
                    end else begin
                        got = exp_q.pop_front();
                        if (bus_write_en !== got.we || bus_addr !== got.addr ||
                            (got.we && bus_write_data !== got.data)) begin
                            errors++;
                            $display("FAIL txn: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                                     bus_write_en, bus_addr, bus_write_data, got.we, got.addr, got.data);
                        end
                    end
                end
            end else begin
                checks++;
                if (bus_addr !== 32'd0 || bus_write_data !== 32'd0) begin
                    errors++;
                    $display("FAIL idle_bus: got addr=%h data=%h, required 0/0", bus_addr, bus_write_data);
                end
            end
            stall_hold = (bus_write_en || bus_read_en) && bus_busywait;
            prev_addr  = bus_addr;
            prev_data  = bus_write_data;
            prev_we    = bus_write_en;
            prev_re    = bus_read_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_buf(input logic [1:0] idx, input logic [31:0] val);
        cur_wr_en   = 1'b1;
        cur_wr_idx  = idx;
        cur_wr_data = val;
        tick();
        cur_wr_en   = 1'b0;
        mbuf[idx]   = val;
    endtask

    // Push the expected transactions of one step and derive latency/results.
    task automatic build_expect(input int stall_extra);
        txn_t t;
        int   reads;
        int   total;
        total   = 0;
        exp_to  = 1'b0;
        for (int n = 0; n < NN; n++) begin
            t.we = 1'b1; t.addr = 32'(n * 64 + 'h14); t.data = mbuf[n];
            exp_q.push_back(t);
            t.addr = 32'(n * 64 + 'h18); t.data = {29'd0, mmode[n], 1'b0, 1'b1};
            exp_q.push_back(t);
        end
        for (int n = 0; n < NN; n++) begin
            reads = (busy_reads[n] + 1 > MP) ? MP : busy_reads[n] + 1;
            total += reads;
            if (busy_reads[n] >= MP) begin
                exp_to     = 1'b1;
                exp_spk[n] = 1'b0;
            end else begin
                exp_spk[n] = spike_bits[n];
            end
            for (int r = 0; r < reads; r++) begin
                t.we = 1'b0; t.addr = 32'(n * 64 + 'h1C); t.data = 32'd0;
                exp_q.push_back(t);
            end
        end
        exp_lat = 2 * NN + SC + total + 1 + stall_extra;
    endtask

    task automatic run_step(input string name, input int stall_extra, input int ignore_at,
                            input bit wr_same, input logic [31:0] wr_val);
        int   lat;
        bit   done;
        int   stall_left;
        bit   stalled;
        stub_clr = 1'b1;
        tick();
        stub_clr = 1'b0;
        cnt58    = 0;
        build_expect(stall_extra);
        step_start = 1'b1;
        if (wr_same) begin
            cur_wr_en = 1'b1; cur_wr_idx = 2'd0; cur_wr_data = wr_val;
        end
        tick();
        step_start = 1'b0;
        cur_wr_en  = 1'b0;
        if (wr_same) mbuf[0] = wr_val;
        checks++;
        if (step_busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: got busy=%b terr=%b, required busy=1 terr=0", name, step_busy, timeout_err);
        end
        lat = 0; done = 0; stall_left = 0; stalled = 0;
        while (!done && lat < 500) begin
            tick();
            lat++;
            step_start = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) bus_busywait = 1'b0;
            end else if (stall_extra > 0 && !stalled && bus_write_en && bus_addr == 32'h58) begin
                stalled      = 1;
                bus_busywait = 1'b1;
                stall_left   = stall_extra;
            end
            if (step_done) done = 1;
            else if (lat == ignore_at) step_start = 1'b1;
        end
        bus_busywait = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done_wait: no step_done within %0d cycles, required one", name, lat);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
        end
        checks++;
        if (spike_vec !== exp_spk || timeout_err !== exp_to || step_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_result: got spk=%b terr=%b busy=%b, required spk=%b terr=%b busy=1",
                     name, spike_vec, timeout_err, step_busy, exp_spk, exp_to);
        end
        tick();
        checks++;
        if (step_done !== 1'b0 || step_busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_end: got done=%b busy=%b pending=%0d, required 0/0/0",
                     name, step_done, step_busy, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        checks++;
        if (step_busy !== 1'b0 || step_done !== 1'b0 || spike_vec !== '0 || timeout_err !== 1'b0 ||
            bus_addr !== 32'd0 || bus_write_en !== 1'b0 || bus_write_data !== 32'd0 || bus_read_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got busy=%b done=%b spk=%b terr=%b addr=%h we=%b wd=%h re=%b, required all 0",
                     step_busy, step_done, spike_vec, timeout_err, bus_addr, bus_write_en, bus_write_data, bus_read_en);
        end
    endtask

    task automatic test_basic();
        for (int n = 0; n < NN; n++) busy_reads[n] = 0;
        spike_bits = 4'b0100;
        run_step("basic", 0, -1, 1'b0, 32'd0);
    endtask

    task automatic test_busy_poll();
        busy_reads[1] = 5;
        spike_bits    = 4'b0110;
        run_step("busy_poll", 0, -1, 1'b0, 32'd0);
        busy_reads[1] = 0;
    endtask

    task automatic test_stall();
        spike_bits = 4'b0100;
        run_step("stall", 3, -1, 1'b0, 32'd0);
        checks++;
        if (cnt58 != 4) begin
            errors++;
            $display("FAIL stall_cycles: got 0x58 presented %0d cycles, required 4", cnt58);
        end
    endtask

    task automatic test_timeout();
        busy_reads[3] = 1000;
        spike_bits    = 4'b1100;
        run_step("timeout", 0, -1, 1'b0, 32'd0);
        busy_reads[3] = 0;
    endtask

    task automatic test_mode_shadow();
        spike_bits = 4'b0001;
        mode_cfg   = 4'b0001;
        mmode      = 4'b0001;
        run_step("mode_shadow", 0, -1, 1'b1, 32'd99);
        mode_cfg   = 4'b0000;
        mmode      = 4'b0000;
        run_step("shadow_next", 0, -1, 1'b0, 32'd0);
    endtask

    task automatic test_ignore();
        bit extra;
        spike_bits = 4'b1010;
        run_step("ignore", 0, 11, 1'b0, 32'd0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_busy || step_done) extra = 1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL ignore_no_restart: got step_busy/step_done activity, required none");
        end
    endtask

    task automatic test_reset_mid_step();
        bit found;
        bit late_done;
        stub_clr = 1'b1;
        tick();
        stub_clr = 1'b0;
        build_expect(0);
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus_write_en && bus_addr[5:0] == 6'h18) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid_find: never saw a control write, required one");
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_write_en !== 1'b0 || bus_read_en !== 1'b0 || bus_addr !== 32'd0 ||
            step_busy !== 1'b0 || spike_vec !== '0 || step_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_values: got we=%b re=%b addr=%h busy=%b spk=%b done=%b, required all 0",
                     bus_write_en, bus_read_en, bus_addr, step_busy, spike_vec, step_done);
        end
        exp_q.delete();
        tick();
        rst = 1'b0;
        late_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (step_done || step_busy) late_done = 1;
        end
        checks++;
        if (late_done) begin
            errors++;
            $display("FAIL rst_mid_no_done: got step activity after reset, required none");
        end
        // buffer was cleared by reset
        for (int n = 0; n < NN; n++) mbuf[n] = 32'd0;
        mmode      = mode_cfg;
        spike_bits = 4'b0011;
        run_step("after_reset", 0, -1, 1'b0, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        cur_wr_en    = 1'b0;
        cur_wr_idx   = 2'd0;
        cur_wr_data  = 32'd0;
        mode_cfg     = '0;
        step_start   = 1'b0;
        bus_busywait = 1'b0;
        stub_clr     = 1'b1;
        stall_hold   = 1'b0;
        mmode        = '0;
        spike_bits   = '0;
        cnt58        = 0;
        for (int n = 0; n < NN; n++) begin
            mbuf[n]       = 32'd0;
            busy_reads[n] = 0;
        end
        repeat (3) tick();
        test_reset();
        rst      = 1'b0;
        stub_clr = 1'b0;
        tick();
        test_reset();
        write_buf(2'd0, 32'd10);
        write_buf(2'd1, 32'd20);
        write_buf(2'd2, 32'd30);
        write_buf(2'd3, 32'd40);
        test_basic();
        test_busy_poll();
        test_stall();
        test_timeout();
        test_mode_shadow();
        test_ignore();
        test_reset_mid_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
